// File: rtl/uart_pkg.sv
// Shared UART definitions: TX FSM state encoding, parity modes and data-width decode helpers.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;

    // 00..11 selects 5..8 data bits
    function automatic logic [3:0] data_bits_count(input logic [1:0] sel);
        return 4'd5 + {2'b00, sel};
    endfunction

    function automatic logic [7:0] data_mask(input logic [1:0] sel);
        logic [7:0] m;
        case (sel)
            2'b00:   m = 8'h1F;
            2'b01:   m = 8'h3F;
            2'b10:   m = 8'h7F;
            default: m = 8'hFF;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Free-running oversampling tick generator: one-clk tick every dvsr+1 clocks.
module uart_baud_gen #(
    parameter int DVSR_WIDTH = 11
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [DVSR_WIDTH-1:0] dvsr,
    output logic                  tick
);
    logic [DVSR_WIDTH-1:0] r_reg;
    logic [DVSR_WIDTH-1:0] r_dvsr;
    logic                  w_wrap;

    // divisor is re-sampled only at the wrap so a change never truncates a period
    assign w_wrap = (r_reg == r_dvsr);
    assign tick   = w_wrap;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_reg  <= '0;
            r_dvsr <= '0;
        end else if (w_wrap) begin
            r_reg  <= '0;
            r_dvsr <= dvsr;
        end else begin
            r_reg  <= r_reg + DVSR_WIDTH'(1);
        end
    end

endmodule

// File: rtl/uart_tx_cfg.sv
// UART transmitter: TX FIFO, baud tick generator and a frame FSM with runtime-selectable
// data width, parity and stop-bit count (all sampled when a byte is popped).
module uart_tx_cfg
    import uart_pkg::*;
#(
    parameter int ADDR_WIDTH = 2,
    parameter int DVSR_WIDTH = 11,
    parameter int SB_TICK    = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [DVSR_WIDTH-1:0] dvsr,
    input  logic [1:0]            data_bits,
    input  logic [1:0]            parity_mode,
    input  logic                  stop2,
    input  logic                  wr_uart,
    input  logic [7:0]            w_data,
    output logic                  tx,
    output logic                  tx_full,
    output logic                  tx_empty,
    output logic [ADDR_WIDTH:0]   tx_level,
    output logic                  tx_busy,
    output logic                  tx_done_tick,
    output logic                  ovf_tick
);
    localparam int DEPTH = 2**ADDR_WIDTH;
    localparam int SW    = $clog2(2*SB_TICK);
    localparam logic [ADDR_WIDTH:0] LVL_FULL = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [SW-1:0]       S_LAST1  = SW'(SB_TICK-1);
    localparam logic [SW-1:0]       S_LAST2  = SW'(2*SB_TICK-1);

    logic [7:0]            r_mem [DEPTH];
    logic [ADDR_WIDTH-1:0] r_wptr, r_rptr;
    logic [ADDR_WIDTH:0]   r_level, w_level_next;
    logic                  r_full, r_empty;
    logic                  w_push, w_pop;
    logic [7:0]            w_head, w_frame_data;

    tx_state_t             r_state, w_state_next;
    logic [SW-1:0]         r_s, w_s_next;
    logic [2:0]            r_n, w_n_next;
    logic [7:0]            r_b, w_b_next;
    logic [1:0]            r_nbits, w_nbits_next;
    logic                  r_par_en, w_par_en_next;
    logic                  r_par_bit, w_par_bit_next;
    logic                  r_stop2, w_stop2_next;
    logic [DVSR_WIDTH-1:0] r_dvsr, w_dvsr_next;
    logic                  w_tick, w_tx, w_done;

    // baud divisor is held per frame so a mid-frame dvsr change cannot stretch the current frame
    uart_baud_gen #(.DVSR_WIDTH(DVSR_WIDTH)) u_baud (
        .clk     (clk),
        .reset_n (reset_n),
        .dvsr    (r_dvsr),
        .tick    (w_tick)
    );

    assign w_push       = wr_uart & ~r_full;
    assign ovf_tick     = wr_uart & r_full;
    assign w_head       = r_mem[r_rptr];
    assign w_frame_data = w_head & data_mask(data_bits);

    always_comb begin
        w_level_next = r_level;
        if (w_push && !w_pop)
            w_level_next = r_level + (ADDR_WIDTH+1)'(1);
        else if (!w_push && w_pop)
            w_level_next = r_level - (ADDR_WIDTH+1)'(1);
    end

    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wptr] <= w_data;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
            r_full  <= 1'b0;
            r_empty <= 1'b1;
        end else begin
            if (w_push)
                r_wptr <= r_wptr + ADDR_WIDTH'(1);
            if (w_pop)
                r_rptr <= r_rptr + ADDR_WIDTH'(1);
            r_level <= w_level_next;
            r_full  <= (w_level_next == LVL_FULL);
            r_empty <= (w_level_next == '0);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= IDLE;
            r_s       <= '0;
            r_n       <= '0;
            r_b       <= '0;
            r_nbits   <= '0;
            r_par_en  <= 1'b0;
            r_par_bit <= 1'b0;
            r_stop2   <= 1'b0;
            r_dvsr    <= '0;
        end else begin
            r_state   <= w_state_next;
            r_s       <= w_s_next;
            r_n       <= w_n_next;
            r_b       <= w_b_next;
            r_nbits   <= w_nbits_next;
            r_par_en  <= w_par_en_next;
            r_par_bit <= w_par_bit_next;
            r_stop2   <= w_stop2_next;
            r_dvsr    <= w_dvsr_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_s_next       = r_s;
        w_n_next       = r_n;
        w_b_next       = r_b;
        w_nbits_next   = r_nbits;
        w_par_en_next  = r_par_en;
        w_par_bit_next = r_par_bit;
        w_stop2_next   = r_stop2;
        w_dvsr_next    = r_dvsr;
        w_pop          = 1'b0;
        w_done         = 1'b0;
        w_tx           = 1'b1;
        case (r_state)
            IDLE: begin
                if (!r_empty) begin
                    w_pop          = 1'b1;
                    w_b_next       = w_frame_data;
                    w_nbits_next   = data_bits;
                    w_par_en_next  = (parity_mode == PAR_EVEN) || (parity_mode == PAR_ODD);
                    w_par_bit_next = (^w_frame_data) ^ (parity_mode == PAR_ODD);
                    w_stop2_next   = stop2;
                    w_dvsr_next    = dvsr;
                    w_s_next       = '0;
                    w_n_next       = '0;
                    w_state_next   = START;
                end
            end
            START: begin
                w_tx = 1'b0;
                if (w_tick) begin
                    if (r_s == S_LAST1) begin
                        w_s_next     = '0;
                        w_state_next = DATA;
                    end else begin
                        w_s_next = r_s + SW'(1);
                    end
                end
            end
            DATA: begin
                w_tx = r_b[0];
                if (w_tick) begin
                    if (r_s == S_LAST1) begin
                        w_s_next = '0;
                        w_b_next = {1'b0, r_b[7:1]};
                        if ({1'b0, r_n} == data_bits_count(r_nbits) - 4'd1)
                            w_state_next = r_par_en ? PARITY : STOP;
                        else
                            w_n_next = r_n + 3'd1;
                    end else begin
                        w_s_next = r_s + SW'(1);
                    end
                end
            end
            PARITY: begin
                w_tx = r_par_bit;
                if (w_tick) begin
                    if (r_s == S_LAST1) begin
                        w_s_next     = '0;
                        w_state_next = STOP;
                    end else begin
                        w_s_next = r_s + SW'(1);
                    end
                end
            end
            STOP: begin
                if (w_tick) begin
                    if (r_s == (r_stop2 ? S_LAST2 : S_LAST1)) begin
                        w_done       = 1'b1;
                        w_state_next = IDLE;
                    end else begin
                        w_s_next = r_s + SW'(1);
                    end
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    assign tx           = w_tx;
    assign tx_full      = r_full;
    assign tx_empty     = r_empty;
    assign tx_level     = r_level;
    assign tx_busy      = (r_state != IDLE);
    assign tx_done_tick = w_done;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Directed bench for uart_tx_cfg: a line monitor decodes frames and checks them against a
// scoreboard of expected frames pushed at write time.
`timescale 1ns/1ps
module tb_uart_tx_cfg;
    localparam int AW = 2;
    localparam int DW = 11;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [DW-1:0] dvsr;
    logic [1:0]    data_bits, parity_mode;
    logic          stop2, wr_uart;
    logic [7:0]    w_data;
    logic          tx, tx_full, tx_empty, tx_busy, tx_done_tick, ovf_tick;
    logic [AW:0]   tx_level;

    always #5 clk = ~clk;

    uart_tx_cfg #(.ADDR_WIDTH(AW), .DVSR_WIDTH(DW), .SB_TICK(16)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .dvsr         (dvsr),
        .data_bits    (data_bits),
        .parity_mode  (parity_mode),
        .stop2        (stop2),
        .wr_uart      (wr_uart),
        .w_data       (w_data),
        .tx           (tx),
        .tx_full      (tx_full),
        .tx_empty     (tx_empty),
        .tx_level     (tx_level),
        .tx_busy      (tx_busy),
        .tx_done_tick (tx_done_tick),
        .ovf_tick     (ovf_tick)
    );

    typedef struct {
        logic [7:0] data;
        int         nbits;
        int         par;    // 0 none, 1 even, 2 odd
        bit         stop2;
        int         bclk;   // clocks per oversampling tick
    } frame_t;

    frame_t sb_q[$];
    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int done_cnt = 0;
    int frames_dec = 0;
    int last_done = 0;
    int last_len = 0;
    int max_gap = 0;
    int gap_cnt = 0;
    int bo = 1;           // clocks per tick of the previous frame (divisor held in the DUT)
    bit gap_en = 1'b0;
    bit mon_en = 1'b1;
    bit mon_busy = 1'b0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (tx_done_tick === 1'b1)
            done_cnt <= done_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic frame_t cur_frame(input logic [7:0] b);
        frame_t f;
        f.data  = b;
        f.nbits = 5 + int'(data_bits);
        f.par   = (parity_mode == 2'b01) ? 1 : (parity_mode == 2'b10) ? 2 : 0;
        f.stop2 = stop2;
        f.bclk  = int'(dvsr) + 1;
        return f;
    endfunction

    task automatic advance(inout int t, input int target);
        while (t < target) begin
            @(negedge clk);
            t++;
        end
    endtask

    // called at the negedge where tx first reads low; t counts clocks from there
    task automatic decode_frame();
        frame_t     e;
        int         t, b, nb, idx, nt, len, lo, hi;
        logic [7:0] got, mask;
        logic       exp_par;
        t = 0;
        got = '0;
        mon_busy = 1'b1;
        if (gap_en) begin
            gap_cnt++;
            if (cyc - last_done > max_gap)
                max_gap = cyc - last_done;
        end
        check("frame_expected", 32'(sb_q.size() != 0), 32'd1);
        if (sb_q.size() == 0) begin
            while (tx_done_tick !== 1'b1 && t < 20000) begin
                @(negedge clk);
                t++;
            end
            mon_busy = 1'b0;
            return;
        end
        e = sb_q.pop_front();
        b = e.bclk;
        nb = e.nbits;
        mask = 8'((1 << nb) - 1);
        for (int k = 0; k < nb; k++) begin
            advance(t, 23*b + 16*b*k);
            got[k] = tx;
        end
        check("data_bits", 32'(got), 32'(e.data & mask));
        idx = nb;
        if (e.par != 0) begin
            exp_par = (^(e.data & mask)) ^ (e.par == 2);
            advance(t, 23*b + 16*b*idx);
            check("parity_bit", 32'(tx), 32'(exp_par));
            idx++;
        end
        advance(t, 23*b + 16*b*idx);
        check("stop_bit1", 32'(tx), 32'd1);
        idx++;
        if (e.stop2) begin
            advance(t, 23*b + 16*b*idx);
            check("stop_bit2", 32'(tx), 32'd1);
        end
        nt = 16 * (1 + nb + ((e.par != 0) ? 1 : 0) + (e.stop2 ? 2 : 1));
        while (tx_done_tick !== 1'b1 && t < nt*b + 8*b) begin
            @(negedge clk);
            t++;
        end
        check("done_tick_seen", 32'(tx_done_tick), 32'd1);
        len = t + 1;
        lo = (nt - 1) * b + 1;
        hi = (nt - 1) * b + ((bo > b) ? bo : b);
        check("frame_len_in_range", 32'(len >= lo && len <= hi), 32'd1);
        $display("frame %0d: data=%02h nbits=%0d par=%0d stop2=%0d bclk=%0d got=%02h len=%0d",
                 frames_dec, e.data, nb, e.par, e.stop2, b, got, len);
        last_len = len;
        last_done = cyc;
        bo = b;
        frames_dec++;
        mon_busy = 1'b0;
    endtask

    initial begin
        logic prev_tx;
        prev_tx = 1'b1;
        forever begin
            @(negedge clk);
            if (reset_n === 1'b1 && mon_en && prev_tx === 1'b1 && tx === 1'b0)
                decode_frame();
            prev_tx = tx;
        end
    end

    task automatic write_byte(input logic [7:0] b, input bit expect_drop, input bit push);
        @(negedge clk);
        wr_uart = 1'b1;
        w_data  = b;
        #1;
        check("ovf_tick", 32'(ovf_tick), 32'(expect_drop));
        if (!expect_drop && push)
            sb_q.push_back(cur_frame(b));
        @(negedge clk);
        wr_uart = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string tag);
        int n;
        n = 0;
        while ((sb_q.size() != 0 || mon_busy || tx_busy) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(n < budget), 32'd1);
    endtask

    task automatic wait_busy(input int budget, input string tag);
        int n;
        n = 0;
        while (tx_busy !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(n < budget), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int done_base;
        reset_n = 1'b0;
        dvsr = DW'(9);
        data_bits = 2'b11;
        parity_mode = 2'b00;
        stop2 = 1'b0;
        wr_uart = 1'b0;
        w_data = 8'h00;
        repeat (3) @(negedge clk);
        #1;
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_full", 32'(tx_full), 32'd0);
        check("rst_empty", 32'(tx_empty), 32'd1);
        check("rst_level", 32'(tx_level), 32'd0);
        check("rst_busy", 32'(tx_busy), 32'd0);
        check("rst_done", 32'(tx_done_tick), 32'd0);
        check("rst_ovf", 32'(ovf_tick), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // 1: 8N1 single byte, entry visible one clk after write, START one clk later
        done_base = done_cnt;
        write_byte(8'h7E, 1'b0, 1'b1);
        #1;
        check("t1_level_after_write", 32'(tx_level), 32'd1);
        check("t1_empty_after_write", 32'(tx_empty), 32'd0);
        check("t1_idle_before_start", 32'(tx_busy), 32'd0);
        @(negedge clk);
        #1;
        check("t1_busy_at_start", 32'(tx_busy), 32'd1);
        check("t1_tx_start_low", 32'(tx), 32'd0);
        check("t1_level_after_pop", 32'(tx_level), 32'd0);
        wait_idle(4000, "t1_idle_timeout");
        check("t1_done_count", 32'(done_cnt - done_base), 32'd1);

        // 2: fill FIFO while busy, overflow write dropped, back-to-back frames
        write_byte(8'h7E, 1'b0, 1'b1);
        wait_busy(200, "t2_busy_timeout");
        write_byte(8'hFF, 1'b0, 1'b1);
        write_byte(8'h55, 1'b0, 1'b1);
        write_byte(8'hD7, 1'b0, 1'b1);
        write_byte(8'h81, 1'b0, 1'b1);
        #1;
        check("t2_full", 32'(tx_full), 32'd1);
        check("t2_level_full", 32'(tx_level), 32'd4);
        write_byte(8'h3C, 1'b1, 1'b0);
        #1;
        check("t2_level_after_ovf", 32'(tx_level), 32'd4);
        max_gap = 0;
        gap_cnt = 0;
        gap_en = 1'b1;
        wait_idle(12000, "t2_idle_timeout");
        gap_en = 1'b0;
        check("t2_gap_count", 32'(gap_cnt), 32'd4);
        check("t2_gap_max_le_1bit", 32'(max_gap >= 1 && max_gap <= 16*10), 32'd1);
        check("t2_empty_end", 32'(tx_empty), 32'd1);

        // 3: 7E1 then 7O1 on 8'h55
        dvsr = DW'(3);
        data_bits = 2'b10;
        parity_mode = 2'b01;
        write_byte(8'h55, 1'b0, 1'b1);
        wait_idle(2000, "t3e_idle_timeout");
        parity_mode = 2'b10;
        write_byte(8'h55, 1'b0, 1'b1);
        wait_idle(2000, "t3o_idle_timeout");

        // 4: 5O2 on 8'hFF, 144-tick frame
        data_bits = 2'b00;
        parity_mode = 2'b10;
        stop2 = 1'b1;
        write_byte(8'hFF, 1'b0, 1'b1);
        wait_idle(2000, "t4_idle_timeout");
        check("t4_frame_len", 32'(last_len >= 143*4+1 && last_len <= 144*4), 32'd1);

        // 5: reset mid-DATA clears everything at once; next frame is clean
        mon_en = 1'b0;
        data_bits = 2'b11;
        parity_mode = 2'b00;
        stop2 = 1'b0;
        write_byte(8'hA5, 1'b0, 1'b0);
        wait_busy(200, "t5_busy_timeout");
        write_byte(8'h3C, 1'b0, 1'b0);
        repeat (256) @(negedge clk);
        #1;
        check("t5_busy_before_rst", 32'(tx_busy), 32'd1);
        reset_n = 1'b0;
        #1;
        check("t5_rst_tx", 32'(tx), 32'd1);
        check("t5_rst_busy", 32'(tx_busy), 32'd0);
        check("t5_rst_empty", 32'(tx_empty), 32'd1);
        check("t5_rst_level", 32'(tx_level), 32'd0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        bo = 1;
        repeat (5) @(negedge clk);
        #1;
        check("t5_idle_after_rst", 32'(tx), 32'd1);
        mon_en = 1'b1;
        write_byte(8'hC3, 1'b0, 1'b1);
        wait_idle(2000, "t5_idle_timeout");

        // 6: config and divisor change mid-frame only affect the next frame
        write_byte(8'h96, 1'b0, 1'b1);
        wait_busy(200, "t6_busy_timeout");
        repeat (20) @(negedge clk);
        dvsr = DW'(5);
        data_bits = 2'b01;
        parity_mode = 2'b01;
        stop2 = 1'b1;
        write_byte(8'h2B, 1'b0, 1'b1);
        wait_idle(4000, "t6_idle_timeout");

        check("frames_decoded", 32'(frames_dec), 32'd12);
        check("scoreboard_empty", 32'(sb_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
